// File: rtl/multicycle_seq_ctrl_pkg.sv
// Shared types and constants for the multicycle R-format sequencer.
package multicycle_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam int         PC_STEP  = 4;

    typedef struct packed {
        logic ir_write;
        logic ab_write;
        logic aluout_write;
        logic reg_write;
    } strobe_t;

    function automatic logic is_rtype(input logic [31:0] word);
        return word[31:26] == OP_RTYPE;
    endfunction

endpackage

// File: rtl/multicycle_seq_ctrl_if.sv
// Control/status bundle between the host + instruction memory (master) and the sequencer (slave).
interface multicycle_seq_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic              ir_write;
    logic              ab_write;
    logic              aluout_write;
    logic              reg_write;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       instr_cnt;
    logic [31:0]       cycle_cnt;

    modport master (
        output start, abort, base_addr, end_addr, instr,
        input  pc, ir_write, ab_write, aluout_write, reg_write,
               busy, done, err, instr_cnt, cycle_cnt
    );

    modport slave (
        input  start, abort, base_addr, end_addr, instr,
        output pc, ir_write, ab_write, aluout_write, reg_write,
               busy, done, err, instr_cnt, cycle_cnt
    );
endinterface

// File: rtl/multicycle_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multicycle R-format sequencer: PC, FETCH/DECODE/EXEC/WB FSM and datapath strobes.
// Optional performance counters are built only when SEQ_PERF_CNT_EN is defined.
module multicycle_seq_ctrl
    import multicycle_seq_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic               clk,
    input logic               rst,
    multicycle_seq_ctrl_if.slave bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [31:0]       ir_q, ir_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] base_al;
    logic [ADDR_W-1:0] pc_next;
    strobe_t           stb;
    logic              busy, done;

    assign base_al = {bus.base_addr[ADDR_W-1:2], 2'b00};
    assign pc_next = pc_q + ADDR_W'(PC_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            end_q   <= '0;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            end_q   <= end_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    // Abort overrides everything, including a coincident start; pc/err hold.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        end_d   = end_q;
        ir_d    = ir_q;
        err_d   = err_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        pc_d    = base_al;
                        end_d   = bus.end_addr;
                        err_d   = 1'b0;
                        state_d = (base_al == bus.end_addr) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ir_d    = bus.instr;
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    if (ir_q == HALT_WORD) begin
                        state_d = ST_DONE;
                    end else if (!is_rtype(ir_q)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: state_d = ST_WB;
                ST_WB: begin
                    pc_d    = pc_next;
                    state_d = (pc_next == end_q) ? ST_DONE : ST_FETCH;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stb  = '0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_FETCH:  begin stb.ir_write     = 1'b1; busy = 1'b1; end
            ST_DECODE: begin stb.ab_write     = 1'b1; busy = 1'b1; end
            ST_EXEC:   begin stb.aluout_write = 1'b1; busy = 1'b1; end
            ST_WB:     begin stb.reg_write    = 1'b1; busy = 1'b1; end
            ST_DONE:   done = 1'b1;
            default:   ;
        endcase
    end

    assign bus.pc           = pc_q;
    assign bus.ir_write     = stb.ir_write;
    assign bus.ab_write     = stb.ab_write;
    assign bus.aluout_write = stb.aluout_write;
    assign bus.reg_write    = stb.reg_write;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.err          = err_q;

`ifdef SEQ_PERF_CNT_EN
    logic        start_acc;
    logic [31:0] instr_cnt, cycle_cnt;

    assign start_acc = bus.start && !bus.abort &&
                       (state_q == ST_IDLE || state_q == ST_DONE);

    sat_counter #(.W(32)) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (state_q == ST_WB),
        .clr_i (start_acc),
        .cnt_o (instr_cnt)
    );

    sat_counter #(.W(32)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (busy),
        .clr_i (start_acc),
        .cnt_o (cycle_cnt)
    );

    assign bus.instr_cnt = instr_cnt;
    assign bus.cycle_cnt = cycle_cnt;
`else
    assign bus.instr_cnt = '0;
    assign bus.cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Directed bench for multicycle_seq_ctrl; counter expectations follow SEQ_PERF_CNT_EN.
module tb_multicycle_seq_ctrl;
`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [31:0] RWORD = 32'h0022_1820;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_seq_ctrl_if #(.ADDR_W(32)) bus ();

    multicycle_seq_ctrl #(.ADDR_W(32), .HALT_WORD(HALT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [16];
    always_comb bus.instr = mem[bus.pc[5:2]];

    logic [3:0] stb;
    assign stb = {bus.ir_write, bus.ab_write, bus.aluout_write, bus.reg_write};

    int n_tests = 0, n_fail = 0;
    int n_ab = 0, n_alu = 0, n_reg = 0;
    always @(posedge clk) begin
        if (bus.ab_write)     n_ab++;
        if (bus.aluout_write) n_alu++;
        if (bus.reg_write)    n_reg++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] b, input logic [31:0] e);
        bus.base_addr = b;
        bus.end_addr  = e;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        while (!bus.done && k < max) begin
            tick();
            k++;
        end
        chk("done_reached", {31'd0, bus.done}, 32'd1);
    endtask

    initial begin
        int a0, r0, b0;
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.base_addr = '0; bus.end_addr = '0;
        for (int i = 0; i < 16; i++) mem[i] = RWORD;
        tick(); tick();
        chk("rst_pc",   bus.pc, 32'd0);
        chk("rst_stb",  {28'd0, stb}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err",  {31'd0, bus.err}, 32'd0);
        chk("rst_icnt", bus.instr_cnt, 32'd0);
        chk("rst_ccnt", bus.cycle_cnt, 32'd0);
        rst = 1'b0;
        tick();

        // basic two-instruction run, with a start attempt while busy
        go(32'h0, 32'h8);
        for (int c = 1; c <= 8; c++) begin
            chk("basic_stb",  {28'd0, stb}, {28'd0, 4'b1000 >> ((c - 1) % 4)});
            chk("basic_busy", {31'd0, bus.busy}, 32'd1);
            if (c == 5) chk("basic_pc_mid", bus.pc, 32'h4);
            if (c == 2) begin bus.start = 1'b1; bus.base_addr = 32'h40; bus.end_addr = 32'h44; end
            if (c == 3) bus.start = 1'b0;
            tick();
        end
        chk("basic_done", {31'd0, bus.done}, 32'd1);
        chk("basic_busy_end", {31'd0, bus.busy}, 32'd0);
        chk("basic_pc", bus.pc, 32'h8);
        chk("basic_icnt", bus.instr_cnt, PERF ? 32'd2 : 32'd0);
        chk("basic_ccnt", bus.cycle_cnt, PERF ? 32'd8 : 32'd0);

        // halt word in the second slot
        mem[1] = HALT;
        a0 = n_alu; r0 = n_reg;
        go(32'h0, 32'h10);
        wait_done(40);
        chk("halt_pc", bus.pc, 32'h4);
        chk("halt_err", {31'd0, bus.err}, 32'd0);
        chk("halt_regw", n_reg - r0, 32'd1);
        chk("halt_aluw", n_alu - a0, 32'd1);
        chk("halt_icnt", bus.instr_cnt, PERF ? 32'd1 : 32'd0);
        chk("halt_ccnt", bus.cycle_cnt, PERF ? 32'd6 : 32'd0);
        mem[1] = RWORD;

        // illegal opcode, started from DONE
        mem[0] = 32'h8C01_0000;
        a0 = n_alu; r0 = n_reg; b0 = n_ab;
        go(32'h0, 32'h8);
        tick(); tick();
        chk("ill_done", {31'd0, bus.done}, 32'd1);
        chk("ill_err", {31'd0, bus.err}, 32'd1);
        chk("ill_abw", n_ab - b0, 32'd1);
        chk("ill_aluw", n_alu - a0, 32'd0);
        chk("ill_regw", n_reg - r0, 32'd0);
        mem[0] = RWORD;

        // abort together with start: abort wins, err held
        bus.abort = 1'b1; bus.start = 1'b1; bus.base_addr = 32'h0; bus.end_addr = 32'h8;
        tick();
        bus.abort = 1'b0; bus.start = 1'b0;
        chk("abst_busy", {31'd0, bus.busy}, 32'd0);
        chk("abst_done", {31'd0, bus.done}, 32'd0);
        chk("abst_err", {31'd0, bus.err}, 32'd1);

        // abort in EXEC, then restart at 0x10
        r0 = n_reg;
        go(32'h0, 32'h8);
        tick(); tick();
        chk("ab_exec_stb", {28'd0, stb}, 32'b0010);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_stb", {28'd0, stb}, 32'd0);
        chk("ab_busy", {31'd0, bus.busy}, 32'd0);
        chk("ab_done", {31'd0, bus.done}, 32'd0);
        tick();
        chk("ab_regw", n_reg - r0, 32'd0);
        go(32'h10, 32'h14);
        chk("ab_new_pc", bus.pc, 32'h10);
        chk("ab_new_stb", {28'd0, stb}, 32'b1000);
        wait_done(20);
        chk("ab_new_end", bus.pc, 32'h14);
        chk("ab_new_err", {31'd0, bus.err}, 32'd0);

        // PC wrap
        r0 = n_reg;
        go(32'hFFFF_FFFC, 32'h0);
        chk("wrap_pc0", bus.pc, 32'hFFFF_FFFC);
        wait_done(20);
        chk("wrap_pc", bus.pc, 32'h0);
        chk("wrap_regw", n_reg - r0, 32'd1);

        // zero-length run
        go(32'h20, 32'h20);
        chk("zero_done", {31'd0, bus.done}, 32'd1);
        chk("zero_stb", {28'd0, stb}, 32'd0);
        chk("zero_pc", bus.pc, 32'h20);
        chk("zero_icnt", bus.instr_cnt, 32'd0);
        chk("zero_ccnt", bus.cycle_cnt, 32'd0);

        // base low bits are dropped
        go(32'h22, 32'h24);
        chk("align_pc0", bus.pc, 32'h20);
        wait_done(20);
        chk("align_pc", bus.pc, 32'h24);

        // rst asserted in WB
        go(32'h0, 32'h8);
        tick(); tick(); tick();
        chk("rstwb_stb", {28'd0, stb}, 32'b0001);
        rst = 1'b1;
        tick();
        r0 = n_reg;
        chk("rstwb_pc", bus.pc, 32'd0);
        chk("rstwb_stbz", {28'd0, stb}, 32'd0);
        chk("rstwb_busy", {31'd0, bus.busy}, 32'd0);
        chk("rstwb_done", {31'd0, bus.done}, 32'd0);
        chk("rstwb_icnt", bus.instr_cnt, 32'd0);
        chk("rstwb_ccnt", bus.cycle_cnt, 32'd0);
        rst = 1'b0;
        tick(); tick();
        chk("rstwb_regw", n_reg - r0, 32'd0);
        chk("rstwb_idle", {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
